// File: rtl/ethernet_sys_nios2_gen2_0_cpu_debug_pkg.sv
// Shared definitions for the debug-slave OCI memory master: FSM states,
// jdo command field positions and the Avalon byte-enable constant.
package ethernet_sys_nios2_gen2_0_cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_WR_REQ = 2'd2,
        ST_DONE   = 2'd3
    } ocimem_state_t;

    localparam int JDO_W       = 38;
    localparam int DATA_W      = 32;
    localparam int ADDR_LSB    = 10;
    localparam int RD_NOW_BIT  = 34;
    localparam int CLR_ERR_BIT = 35;
    localparam int WDATA_LSB   = 3;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    // Write payload carried in a take_action_ocimem_b command.
    function automatic logic [DATA_W-1:0] jdo_wdata(input logic [JDO_W-1:0] jdo);
        return jdo[WDATA_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/ethernet_sys_nios2_gen2_0_cpu_debug_ocimem_timeout.sv
// Request timeout timer. Down-counter loaded with TIMEOUT_CYCLES-1 while
// cleared and decremented while enabled; expired flags the terminal count,
// i.e. the last cycle a request may remain stalled.
module ethernet_sys_nios2_gen2_0_cpu_debug_ocimem_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Reload on clear, count down while enabled, hold at terminal count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= TC_LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/blk_b3e33a.sv
// OCI memory master for the Nios II debug slave. Turns jdo commands and
// take_action strobes into single-word Avalon-MM reads/writes and returns
// MonDReg, monitor_ready and monitor_error for JTAG shift-out.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a command; address-only loads stay here
//   RD_REQ | avm_read held until accepted or timed out
//   WR_REQ | avm_write held until accepted or timed out
//   DONE   | one cycle; raises monitor_ready, then back to IDLE
module blk_b3e33a
    import ethernet_sys_nios2_gen2_0_cpu_debug_pkg::*;
#(
    parameter int ADDR_W         = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_t     state;
    logic [ADDR_W-1:0] mon_a_reg;
    logic [ADDR_W-1:0] cmd_addr;
    logic              any_strobe;
    logic              in_req;
    logic              tmo_expired;
    logic              unused_jdo;

    assign cmd_addr   = jdo[ADDR_LSB +: ADDR_W];
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign in_req     = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign unused_jdo = ^{jdo[JDO_W-1:CLR_ERR_BIT+1], jdo[WDATA_LSB-1:0]};

    // Timer runs only while a request is outstanding; it is reloaded in
    // every other state so each request starts from a full budget.
    ethernet_sys_nios2_gen2_0_cpu_debug_ocimem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_req),
        .enable  (in_req),
        .expired (tmo_expired)
    );

    // Command decode, request handshake and status flags in one registered FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Priority: address load, then write, then plain read.
                    if (take_action_ocimem_a) begin
                        mon_a_reg     <= cmd_addr;
                        monitor_ready <= 1'b0;
                        if (jdo[CLR_ERR_BIT]) begin
                            monitor_error <= 1'b0;
                        end
                        if (jdo[RD_NOW_BIT]) begin
                            avm_read <= 1'b1;
                            state    <= ST_RD_REQ;
                        end
                    end else if (take_action_ocimem_b) begin
                        avm_writedata <= jdo_wdata(jdo);
                        avm_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= ST_WR_REQ;
                    end else if (take_no_action_ocimem_a) begin
                        avm_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= ST_RD_REQ;
                    end
                end

                ST_RD_REQ: begin
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        MonDReg   <= avm_readdata;
                        mon_a_reg <= mon_a_reg + ADDR_W'(1);
                        avm_read  <= 1'b0;
                        state     <= ST_DONE;
                    end else if (tmo_expired) begin
                        // Abandon the stalled read; address and data stay put.
                        avm_read      <= 1'b0;
                        monitor_error <= 1'b1;
                        state         <= ST_DONE;
                    end
                end

                ST_WR_REQ: begin
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        mon_a_reg <= mon_a_reg + ADDR_W'(1);
                        avm_write <= 1'b0;
                        state     <= ST_DONE;
                    end else if (tmo_expired) begin
                        avm_write     <= 1'b0;
                        monitor_error <= 1'b1;
                        state         <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // A strobe here arrives before the FSM can accept it.
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    monitor_ready <= 1'b1;
                    state         <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm_address    = {mon_a_reg, 2'b00};
    assign avm_byteenable = BYTEEN_ALL;

endmodule

// File: tb/tb_blk_b3e33a.sv
// Directed bench for blk_b3e33a with a transaction-level reference model,
// a per-cycle compare process and literal spot checks.
module tb_blk_b3e33a;

    localparam int TMO = 8;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_n, take_b;
    logic [25:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 0;

    int stall_cycles = 0;
    int req_age = 0;
    int run_len = 0;
    int last_req_len = 0;

    blk_b3e33a #(.ADDR_W(24), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_n),
        .take_action_ocimem_b    (take_b),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: phase 0 = no transfer, 1 = request outstanding,
    // 2 = completion cycle before the next command may be taken.
    logic [23:0] m_addr;
    logic [31:0] m_data, m_wdata;
    logic        m_err, m_ready, m_wr, m_any;
    int          m_phase, m_age;

    initial begin
        m_addr = 0; m_data = 0; m_wdata = 0; m_err = 0; m_ready = 1;
        m_wr = 0; m_phase = 0; m_age = 0;
    end

    always @(posedge clk) begin
        m_any = take_a | take_b | take_n;
        if (reset) begin
            m_addr = 0; m_data = 0; m_wdata = 0; m_err = 0; m_ready = 1;
            m_wr = 0; m_phase = 0; m_age = 0;
        end else if (m_phase == 0) begin
            if (take_a) begin
                m_addr  = jdo[33:10];
                m_ready = 0;
                if (jdo[35]) m_err = 0;
                if (jdo[34]) begin m_phase = 1; m_wr = 0; m_age = 0; end
            end else if (take_b) begin
                m_wdata = jdo[34:3];
                m_ready = 0; m_phase = 1; m_wr = 1; m_age = 0;
            end else if (take_n) begin
                m_ready = 0; m_phase = 1; m_wr = 0; m_age = 0;
            end
        end else if (m_phase == 1) begin
            if (m_any) m_err = 1;
            if (!avm_waitrequest) begin
                if (!m_wr) m_data = avm_readdata;
                m_addr  = m_addr + 24'd1;
                m_phase = 2;
            end else if (m_age == TMO - 1) begin
                m_err   = 1;
                m_phase = 2;
            end else begin
                m_age++;
            end
        end else begin
            if (m_any) m_err = 1;
            m_ready = 1;
            m_phase = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (avm_read === 1'b1 || avm_write === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            last_req_len = run_len;
            run_len = 0;
        end
        if (check_en) begin
            check("avm_address",    avm_address,    {m_addr, 2'b00});
            check("avm_read",       avm_read,       (m_phase == 1) && !m_wr);
            check("avm_write",      avm_write,      (m_phase == 1) && m_wr);
            check("avm_writedata",  avm_writedata,  m_wdata);
            check("avm_byteenable", avm_byteenable, 4'hF);
            check("MonDReg",        MonDReg,        m_data);
            check("monitor_ready",  monitor_ready,  m_ready);
            check("monitor_error",  monitor_error,  m_err);
            check("rd_wr_exclusive", avm_read & avm_write, 1'b0);
        end
    end

    // ---------------- slave responder ----------------
    always @(posedge clk) begin
        #1;
        if (avm_read === 1'b1 || avm_write === 1'b1) begin
            avm_waitrequest = (req_age < stall_cycles);
            req_age++;
        end else begin
            avm_waitrequest = 1'b0;
            req_age = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [23:0] addr, input logic rd_now, input logic clr);
        logic [37:0] d;
        d = '0;
        d[33:10] = addr;
        d[34] = rd_now;
        d[35] = clr;
        return d;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] wdata);
        logic [37:0] d;
        d = '0;
        d[34:3] = wdata;
        return d;
    endfunction

    task automatic strobe(input logic sa, input logic sb, input logic sn, input logic [37:0] d);
        jdo = d; take_a = sa; take_b = sb; take_n = sn;
        cyc(1);
        jdo = '0; take_a = 0; take_b = 0; take_n = 0;
    endtask

    task automatic wait_ready(input string name, input int bound);
        int k;
        k = 0;
        while (monitor_ready !== 1'b1 && k < bound) begin
            cyc(1);
            k++;
        end
        check({name, "_ready_in_time"}, monitor_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1; jdo = '0; take_a = 0; take_b = 0; take_n = 0;
        avm_readdata = '0; avm_waitrequest = 0;
        cyc(3);
        check_en = 1;
        check("rst_ready", monitor_ready, 1'b1);
        check("rst_error", monitor_error, 1'b0);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_address", avm_address, 26'h0);
        check("rst_read", avm_read, 1'b0);
        reset = 0;
        cyc(1);

        // zero-wait read at 0x100
        stall_cycles = 0; avm_readdata = 32'hCAFEF00D;
        strobe(1, 0, 0, mk_a(24'h000100, 1, 0));
        check("zw_read_high", avm_read, 1'b1);
        check("zw_address", avm_address, 26'h0000400);
        cyc(1);
        check("zw_read_low", avm_read, 1'b0);
        check("zw_mondreg", MonDReg, 32'hCAFEF00D);
        check("zw_ready_not_yet", monitor_ready, 1'b0);
        cyc(1);
        check("zw_ready", monitor_ready, 1'b1);
        check("zw_addr_inc", avm_address, 26'h0000404);
        check("zw_req_len", last_req_len, 1);

        // write with 5 wait cycles
        stall_cycles = 5;
        strobe(0, 1, 0, mk_b(32'h12345678));
        check("wr_write_high", avm_write, 1'b1);
        check("wr_wdata", avm_writedata, 32'h12345678);
        check("wr_address", avm_address, 26'h0000404);
        wait_ready("wr", 40);
        check("wr_req_len", last_req_len, 6);
        check("wr_addr_inc", avm_address, 26'h0000408);
        check("wr_error", monitor_error, 1'b0);

        // timeout on a stuck read
        stall_cycles = 255; avm_readdata = 32'h11112222;
        strobe(0, 0, 1, '0);
        wait_ready("tmo", 40);
        check("tmo_req_len", last_req_len, TMO);
        check("tmo_error", monitor_error, 1'b1);
        check("tmo_mondreg", MonDReg, 32'hCAFEF00D);
        check("tmo_addr_hold", avm_address, 26'h0000408);
        strobe(1, 0, 0, mk_a(24'h000002, 0, 1));
        check("clr_error", monitor_error, 1'b0);
        check("clr_addr", avm_address, 26'h0000008);
        check("clr_ready_low", monitor_ready, 1'b0);

        // address wrap
        stall_cycles = 0; avm_readdata = 32'h0BADBEEF;
        strobe(1, 0, 0, mk_a(24'hFFFFFF, 0, 0));
        check("wrap_load", avm_address, 26'h3FFFFFC);
        strobe(0, 0, 1, '0);
        wait_ready("wrap", 20);
        check("wrap_addr", avm_address, 26'h0);
        check("wrap_mondreg", MonDReg, 32'h0BADBEEF);

        // write strobe while a read is outstanding
        stall_cycles = 3; avm_readdata = 32'h5A5A0001;
        strobe(0, 0, 1, '0);
        strobe(0, 1, 0, mk_b(32'hFFFF0000));
        check("ovr_no_write", avm_write, 1'b0);
        check("ovr_error", monitor_error, 1'b1);
        wait_ready("ovr", 20);
        check("ovr_addr", avm_address, 26'h0000004);
        check("ovr_mondreg", MonDReg, 32'h5A5A0001);
        check("ovr_wdata_kept", avm_writedata, 32'h12345678);

        // a and b together: address load only
        strobe(1, 1, 0, mk_a(24'h000010, 0, 1));
        check("pri_no_write", avm_write, 1'b0);
        check("pri_addr", avm_address, 26'h0000040);
        check("pri_error", monitor_error, 1'b0);
        cyc(2);
        check("pri_still_idle", avm_write | avm_read, 1'b0);

        // strobe during DONE is an overrun; DONE+1 accepts
        stall_cycles = 0; avm_readdata = 32'h00C0FFEE;
        strobe(0, 0, 1, '0);
        cyc(1);
        check("b2b_no_err_yet", monitor_error, 1'b0);
        strobe(0, 0, 1, '0);
        check("b2b_done_overrun", monitor_error, 1'b1);
        check("b2b_ready", monitor_ready, 1'b1);
        check("b2b_read_low", avm_read, 1'b0);
        strobe(0, 0, 1, '0);
        check("b2b_accept", avm_read, 1'b1);
        check("b2b_addr", avm_address, 26'h0000044);
        wait_ready("b2b", 20);
        check("b2b_addr_inc", avm_address, 26'h0000048);

        // reset on the third wait cycle of a read
        strobe(1, 0, 0, mk_a(24'h000000, 0, 1));
        stall_cycles = 255; avm_readdata = 32'hDEADDEAD;
        strobe(0, 0, 1, '0);
        cyc(2);
        check("rstm_read_before", avm_read, 1'b1);
        reset = 1;
        cyc(1);
        reset = 0;
        check("rstm_read", avm_read, 1'b0);
        check("rstm_addr", avm_address, 26'h0);
        check("rstm_ready", monitor_ready, 1'b1);
        check("rstm_error", monitor_error, 1'b0);
        check("rstm_mondreg", MonDReg, 32'h0);
        cyc(3);

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
